// File: rtl/operand_fetch_rf_pkg.sv
// Shared constants and types for the operand-fetch register file slice.
// The WB_BYPASS_EN option itself is consumed in operand_fetch_rf.sv.
package operand_fetch_rf_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = $clog2(NREGS);
  localparam int CNT_W  = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam reg_idx_t REG_ZERO = '0;

  function automatic cnt_t popcount(input logic [NREGS-1:0] v);
    cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + cnt_t'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/operand_fetch_rf_if.sv
// Decode / write-back facing bus of the operand-fetch register file.
// Handshake: decode holds rd_req and its fields; the request is taken in any cycle where stall=0 and flush=0.
interface operand_fetch_rf_if;
  import operand_fetch_rf_pkg::*;

  logic     wb_en;
  reg_idx_t wb_addr;
  data_t    wb_data;
  logic     rd_req;
  reg_idx_t rs_addr;
  reg_idx_t rt_addr;
  logic     dst_vld;
  reg_idx_t dst_addr;
  logic     flush;
  logic     stall;
  logic     op_valid;
  data_t    rs_data;
  data_t    rt_data;
  cnt_t     pend_cnt;

  modport master (
    output wb_en, wb_addr, wb_data, rd_req, rs_addr, rt_addr, dst_vld, dst_addr, flush,
    input  stall, op_valid, rs_data, rt_data, pend_cnt
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, rd_req, rs_addr, rt_addr, dst_vld, dst_addr, flush,
    output stall, op_valid, rs_data, rt_data, pend_cnt
  );

endinterface

// File: rtl/operand_fetch_rf_scoreboard.sv
// Pending-destination scoreboard: flush beats everything, a set beats a clear on the same index.
// pend_cnt is registered alongside the pending vector so it always matches it.
module operand_fetch_rf_scoreboard
  import operand_fetch_rf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_en,
  input  reg_idx_t         clr_idx,
  input  logic             set_en,
  input  reg_idx_t         set_idx,
  input  logic             flush,
  output logic [NREGS-1:0] pending,
  output cnt_t             pend_cnt
);

  logic [NREGS-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_idx] = 1'b0;
    if (set_en) pending_nxt[set_idx] = 1'b1;
    pending_nxt[REG_ZERO] = 1'b0;
    if (flush) pending_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= popcount(pending_nxt);
    end
  end

endmodule

// File: rtl/operand_fetch_rf.sv
// Register file with two registered operand reads and RAW stall against in-flight destinations.
// Optional `WB_BYPASS_EN forwards a same-cycle write-back into the operands and suppresses its stall.
module operand_fetch_rf
  import operand_fetch_rf_pkg::*;
(
  input logic               clk,
  input logic               reset,
  operand_fetch_rf_if.slave bus
);

  data_t            regs [NREGS];
  logic [NREGS-1:0] pending;
  logic             haz_rs;
  logic             haz_rt;
  logic             accept;
  data_t            rs_rd;
  data_t            rt_rd;

  function automatic data_t read_port(input reg_idx_t idx, input data_t arr_val);
    data_t v;
    v = arr_val;
`ifdef WB_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == idx) v = bus.wb_data;
`endif
    if (idx == REG_ZERO) v = '0;
    return v;
  endfunction

  function automatic logic hazard(input reg_idx_t idx);
    logic h;
    h = pending[idx] && (idx != REG_ZERO);
`ifdef WB_BYPASS_EN
    // The write-back landing this cycle satisfies the dependency through the bypass.
    if (bus.wb_en && bus.wb_addr == idx) h = 1'b0;
`endif
    return h;
  endfunction

  always_comb begin
    haz_rs    = hazard(bus.rs_addr);
    haz_rt    = hazard(bus.rt_addr);
    bus.stall = bus.rd_req && !bus.flush && (haz_rs || haz_rt);
    accept    = bus.rd_req && !bus.stall && !bus.flush;
    rs_rd     = read_port(bus.rs_addr, regs[bus.rs_addr]);
    rt_rd     = read_port(bus.rt_addr, regs[bus.rt_addr]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != REG_ZERO) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Operands hold their last values when nothing is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.op_valid <= 1'b0;
      bus.rs_data  <= '0;
      bus.rt_data  <= '0;
    end else begin
      bus.op_valid <= accept;
      if (accept) begin
        bus.rs_data <= rs_rd;
        bus.rt_data <= rt_rd;
      end
    end
  end

  operand_fetch_rf_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (bus.wb_en),
    .clr_idx  (bus.wb_addr),
    .set_en   (accept && bus.dst_vld),
    .set_idx  (bus.dst_addr),
    .flush    (bus.flush),
    .pending  (pending),
    .pend_cnt (bus.pend_cnt)
  );

endmodule

// File: tb/tb_operand_fetch_rf.sv
// Directed bench for operand_fetch_rf; expectations follow the WB_BYPASS_EN setting of the build.
module tb_operand_fetch_rf;
  import operand_fetch_rf_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  operand_fetch_rf_if bus ();

  operand_fetch_rf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rs_addr  = '0;
    bus.rt_addr  = '0;
    bus.dst_vld  = 1'b0;
    bus.dst_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic wb(input reg_idx_t a, input data_t d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  task automatic rd(input reg_idx_t rs, input reg_idx_t rt, input logic dv, input reg_idx_t dst);
    bus.rd_req   = 1'b1;
    bus.rs_addr  = rs;
    bus.rt_addr  = rt;
    bus.dst_vld  = dv;
    bus.dst_addr = dst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.op_valid), 32'h0);
    check("rst_rs", 32'(bus.rs_data), 32'h0);
    check("rst_rt", 32'(bus.rt_data), 32'h0);
    check("rst_pend", 32'(bus.pend_cnt), 32'h0);
    reset = 1'b1;

    // write then read
    wb(3'd3, 16'hBEEF);
    step();
    idle();
    rd(3'd3, 3'd0, 1'b0, 3'd0);
    #1 check("wr_rd_stall", 32'(bus.stall), 32'h0);
    step();
    idle();
    check("wr_rd_valid", 32'(bus.op_valid), 32'h1);
    check("wr_rd_rs", 32'(bus.rs_data), 32'hBEEF);
    check("wr_rd_rt", 32'(bus.rt_data), 32'h0);
    step();
    check("idle_valid", 32'(bus.op_valid), 32'h0);
    check("idle_rs_hold", 32'(bus.rs_data), 32'hBEEF);

    // RAW stall on r5
    rd(3'd0, 3'd0, 1'b1, 3'd5);
    #1 check("raw_prod_stall", 32'(bus.stall), 32'h0);
    step();
    idle();
    check("raw_pend1", 32'(bus.pend_cnt), 32'h1);
    rd(3'd5, 3'd0, 1'b0, 3'd0);
    #1 check("raw_stall", 32'(bus.stall), 32'h1);
    step();
    check("raw_stall_hold", 32'(bus.stall), 32'h1);
    check("raw_no_valid", 32'(bus.op_valid), 32'h0);
    wb(3'd5, 16'h1234);
    #1;
`ifdef WB_BYPASS_EN
    check("raw_wb_stall", 32'(bus.stall), 32'h0);
    step();
    idle();
    check("raw_valid", 32'(bus.op_valid), 32'h1);
    check("raw_rs", 32'(bus.rs_data), 32'h1234);
    check("raw_pend0", 32'(bus.pend_cnt), 32'h0);
`else
    check("raw_wb_stall", 32'(bus.stall), 32'h1);
    step();
    bus.wb_en = 1'b0;
    #1 check("raw_after_stall", 32'(bus.stall), 32'h0);
    check("raw_pend0", 32'(bus.pend_cnt), 32'h0);
    step();
    idle();
    check("raw_valid", 32'(bus.op_valid), 32'h1);
    check("raw_rs", 32'(bus.rs_data), 32'h1234);
`endif

    // set/clear collision on r2
    rd(3'd0, 3'd0, 1'b1, 3'd2);
    step();
    idle();
    check("coll_pend_pre", 32'(bus.pend_cnt), 32'h1);
    wb(3'd2, 16'h2222);
    rd(3'd0, 3'd0, 1'b1, 3'd2);
    #1 check("coll_acc_stall", 32'(bus.stall), 32'h0);
    step();
    idle();
    check("coll_pend", 32'(bus.pend_cnt), 32'h1);
    rd(3'd2, 3'd0, 1'b0, 3'd0);
    #1 check("coll_stall", 32'(bus.stall), 32'h1);
    idle();
    wb(3'd2, 16'h3333);
    step();
    idle();
    check("coll_cleared", 32'(bus.pend_cnt), 32'h0);

    // r0 rules
    wb(3'd0, 16'hFFFF);
    rd(3'd0, 3'd0, 1'b1, 3'd0);
    #1 check("r0_stall", 32'(bus.stall), 32'h0);
    step();
    idle();
    check("r0_pend", 32'(bus.pend_cnt), 32'h0);
    check("r0_valid", 32'(bus.op_valid), 32'h1);
    check("r0_rs", 32'(bus.rs_data), 32'h0);
    check("r0_rt", 32'(bus.rt_data), 32'h0);

    // flush with three pending registers
    rd(3'd0, 3'd0, 1'b1, 3'd1);
    step();
    rd(3'd0, 3'd0, 1'b1, 3'd4);
    step();
    rd(3'd0, 3'd0, 1'b1, 3'd6);
    step();
    idle();
    check("fl_pend3", 32'(bus.pend_cnt), 32'h3);
    check("fl_pre_valid", 32'(bus.op_valid), 32'h1);
    rd(3'd1, 3'd4, 1'b0, 3'd0);
    #1 check("fl_pre_stall", 32'(bus.stall), 32'h1);
    bus.flush = 1'b1;
    wb(3'd4, 16'h4444);
    #1 check("fl_stall", 32'(bus.stall), 32'h0);
    step();
    idle();
    check("fl_pend0", 32'(bus.pend_cnt), 32'h0);
    check("fl_valid", 32'(bus.op_valid), 32'h0);
    rd(3'd1, 3'd4, 1'b0, 3'd0);
    #1 check("fl_post_stall", 32'(bus.stall), 32'h0);
    step();
    idle();
    check("fl_post_valid", 32'(bus.op_valid), 32'h1);
    check("fl_post_rs", 32'(bus.rs_data), 32'h0);
    check("fl_post_rt", 32'(bus.rt_data), 32'h4444);

    // asynchronous reset mid-traffic
    rd(3'd3, 3'd0, 1'b1, 3'd7);
    step();
    check("ar_pre_valid", 32'(bus.op_valid), 32'h1);
    check("ar_pre_rs", 32'(bus.rs_data), 32'hBEEF);
    check("ar_pre_pend", 32'(bus.pend_cnt), 32'h1);
    rd(3'd3, 3'd3, 1'b0, 3'd0);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", 32'(bus.op_valid), 32'h0);
    check("ar_rs", 32'(bus.rs_data), 32'h0);
    check("ar_rt", 32'(bus.rt_data), 32'h0);
    check("ar_pend", 32'(bus.pend_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    rd(3'd3, 3'd0, 1'b0, 3'd0);
    #1 check("ar_post_stall", 32'(bus.stall), 32'h0);
    step();
    idle();
    check("ar_post_valid", 32'(bus.op_valid), 32'h1);
    check("ar_post_rs", 32'(bus.rs_data), 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
